// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and the
// sequencer state encoding used by the iterative MUL/DIV unit.
package alu_pkg;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_OR  = 4'd3;
  localparam logic [3:0] MODE_XOR = 4'd4;
  localparam logic [3:0] MODE_NOT = 4'd5;
  localparam logic [3:0] MODE_SHL = 4'd6;
  localparam logic [3:0] MODE_SHR = 4'd7;
  localparam logic [3:0] MODE_ADC = 4'd8;
  localparam logic [3:0] MODE_SBB = 4'd9;
  localparam logic [3:0] MODE_CMP = 4'd10;
  localparam logic [3:0] MODE_MUL = 4'd11;
  localparam logic [3:0] MODE_DIV = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider. One step per
// clock; done_o marks the edge on which the final step (and hi_o/lo_o) lands.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  alu_state_t       state_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // MUL partial-product high half / DIV remainder
  logic [WIDTH-1:0] lo_q;    // MUL multiplier bits / DIV dividend -> quotient
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] hi_d, lo_d;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    hi_d     = acc_q;
    lo_d     = lo_q;
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    if (state_q == DIV) begin
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = (state_q != IDLE) && (cnt_q == CW'(1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;
  assign busy_o = busy_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= div_i ? DIV : MUL;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            acc_q   <= '0;
            lo_q    <= a_i;
            opb_q   <= b_i;
          end
        end
        MUL, DIV: begin
          acc_q <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle combinational unit, flag generation and
// output registers, selecting between it and the iterative MUL/DIV unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             fz,
  output logic             fc,
  output logic             fv,
  output logic             fn,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] result_q, hi_q;
  logic             fz_q, fc_q, fv_q, fn_q, done_q, div_q;

  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic             accept, start, carry_in, borrow_in, add_v, sub_v;
  logic [WIDTH:0]   add_x, sub_x;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_c, sc_v, sc_hold;

  assign accept = en && !md_busy;
  // Divide by zero skips the iterative unit and finishes in the single-cycle path.
  assign start  = accept && ((mode == MODE_MUL) || ((mode == MODE_DIV) && (in_b != '0)));

  assign carry_in  = (mode == MODE_ADC) && fc_q;
  assign borrow_in = (mode == MODE_SBB) && fc_q;
  assign add_x = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
  assign sub_x = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, borrow_in};
  assign add_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_x[WIDTH-1] != in_a[WIDTH-1]);
  assign sub_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_x[WIDTH-1] != in_a[WIDTH-1]);

  always_comb begin
    sc_res  = in_a;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_hold = 1'b0;
    case (mode)
      MODE_ADD, MODE_ADC: begin
        sc_res = add_x[WIDTH-1:0];
        sc_c   = add_x[WIDTH];
        sc_v   = add_v;
      end
      MODE_SUB, MODE_SBB, MODE_CMP: begin
        sc_res  = sub_x[WIDTH-1:0];
        sc_c    = sub_x[WIDTH];
        sc_v    = sub_v;
        sc_hold = (mode == MODE_CMP);
      end
      MODE_AND: sc_res = in_a & in_b;
      MODE_OR:  sc_res = in_a | in_b;
      MODE_XOR: sc_res = in_a ^ in_b;
      MODE_NOT: sc_res = ~in_a;
      MODE_SHL: {sc_c, sc_res} = {in_a, 1'b0};
      MODE_SHR: {sc_res, sc_c} = {1'b0, in_a};
      MODE_DIV: begin
        sc_res = '1;
        sc_hi  = in_a;
        sc_v   = 1'b1;
      end
      default: sc_res = in_a;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .div_i   (mode == MODE_DIV),
    .a_i     (in_a),
    .b_i     (in_b),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      hi_q     <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      fn_q     <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) div_q <= (mode == MODE_DIV);
      if (md_done) begin
        result_q <= md_lo;
        hi_q     <= md_hi;
        fz_q     <= div_q ? (md_lo == '0) : ({md_hi, md_lo} == '0);
        fc_q     <= !div_q && (md_hi != '0);
        fv_q     <= 1'b0;
        fn_q     <= div_q ? md_lo[WIDTH-1] : md_hi[WIDTH-1];
        done_q   <= 1'b1;
      end else if (accept && !start) begin
        if (!sc_hold) begin
          result_q <= sc_res;
          hi_q     <= sc_hi;
        end
        fz_q   <= (sc_res == '0);
        fc_q   <= sc_c;
        fv_q   <= sc_v;
        fn_q   <= sc_res[WIDTH-1];
        done_q <= 1'b1;
      end
    end
  end

  assign result    = result_q;
  assign result_hi = hi_q;
  assign fz        = fz_q;
  assign fc        = fc_q;
  assign fv        = fv_q;
  assign fn        = fn_q;
  assign busy      = md_busy;
  assign done      = done_q;

endmodule
